// File: rtl/csit_luks_pkg.sv
// Shared types and glyph constants for the seven-segment display path.
// Glyph bit order is {g,f,e,d,c,b,a}, active-high.
package csit_luks_pkg;

    typedef logic [6:0] seg_t;

    localparam seg_t SEG_HEX_0 = 7'h3F;
    localparam seg_t SEG_HEX_1 = 7'h06;
    localparam seg_t SEG_HEX_2 = 7'h5B;
    localparam seg_t SEG_HEX_3 = 7'h4F;
    localparam seg_t SEG_HEX_4 = 7'h66;
    localparam seg_t SEG_HEX_5 = 7'h6D;
    localparam seg_t SEG_HEX_6 = 7'h7D;
    localparam seg_t SEG_HEX_7 = 7'h07;
    localparam seg_t SEG_HEX_8 = 7'h7F;
    localparam seg_t SEG_HEX_9 = 7'h6F;
    localparam seg_t SEG_HEX_A = 7'h77;
    localparam seg_t SEG_HEX_B = 7'h7C;
    localparam seg_t SEG_HEX_C = 7'h39;
    localparam seg_t SEG_HEX_D = 7'h5E;
    localparam seg_t SEG_HEX_E = 7'h79;
    localparam seg_t SEG_HEX_F = 7'h71;
    localparam seg_t SEG_BLANK = 7'h00;

    typedef enum logic {
        BLANK = 1'b0,
        ON    = 1'b1
    } scan_state_t;

endpackage

// File: rtl/hex_to_seg.sv
// Combinational hex nibble to seven-segment glyph decoder.
module hex_to_seg
    import csit_luks_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    // Glyph lookup
    always_comb begin
        seg = SEG_BLANK;
        case (nibble)
            4'h0:    seg = SEG_HEX_0;
            4'h1:    seg = SEG_HEX_1;
            4'h2:    seg = SEG_HEX_2;
            4'h3:    seg = SEG_HEX_3;
            4'h4:    seg = SEG_HEX_4;
            4'h5:    seg = SEG_HEX_5;
            4'h6:    seg = SEG_HEX_6;
            4'h7:    seg = SEG_HEX_7;
            4'h8:    seg = SEG_HEX_8;
            4'h9:    seg = SEG_HEX_9;
            4'hA:    seg = SEG_HEX_A;
            4'hB:    seg = SEG_HEX_B;
            4'hC:    seg = SEG_HEX_C;
            4'hD:    seg = SEG_HEX_D;
            4'hE:    seg = SEG_HEX_E;
            4'hF:    seg = SEG_HEX_F;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg_scan_scheduler.sv
// Four-digit scan controller sharing the display between a base value and a timed overlay.
// Optional build macro LEADING_ZERO_BLANK_EN blanks leading zeros of base-source frames.
module seg_scan_scheduler #(
    parameter int DIGIT_TICKS = 1000,
    parameter int BLANK_TICKS = 16,
    parameter int OVL_FRAMES  = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] base_val,
    input  logic        ovl_req,
    input  logic [15:0] ovl_val,
    output logic        ovl_ack,
    output logic        ovl_busy,
    output logic [6:0]  seg,
    output logic [3:0]  an,
    output logic [1:0]  digit_idx
);
    import csit_luks_pkg::*;

    localparam int TICK_MAX = (DIGIT_TICKS > BLANK_TICKS) ? DIGIT_TICKS : BLANK_TICKS;
    localparam int TW = $clog2(TICK_MAX + 1);
    localparam int FW = $clog2(OVL_FRAMES + 1);
    localparam logic [TW-1:0] BLANK_LAST = TW'(BLANK_TICKS - 1);
    localparam logic [TW-1:0] DIGIT_LAST = TW'(DIGIT_TICKS - 1);
    localparam logic [TW-1:0] TICK_ONE   = TW'(1);
    localparam logic [FW-1:0] OVL_LAST   = FW'(OVL_FRAMES - 1);
    localparam logic [FW-1:0] FRAME_ONE  = FW'(1);

    scan_state_t   state_r, state_s;
    logic [TW-1:0] tick_r, tick_s;
    logic [1:0]    digit_r, digit_s;
    logic [15:0]   snap_r, snap_s;
    logic [15:0]   ovl_reg_r, ovl_reg_s;
    logic          busy_r, busy_s;
    logic          ack_r, ack_s;
    logic          showing_r, showing_s;
    logic [FW-1:0] frame_cnt_r, frame_cnt_s;
    logic [6:0]    seg_r, seg_s;
    logic [3:0]    an_r, an_s;
    logic [3:0]    nib_s;
    logic [6:0]    dec_s;
    logic          lzb_s;
    logic          snap_cycle_s;
    logic          frame_end_s;

    assign snap_cycle_s = (state_r == BLANK) && (tick_r == BLANK_LAST) && (digit_r == 2'd0);
    assign frame_end_s  = (state_r == ON) && (tick_r == DIGIT_LAST) && (digit_r == 2'd3);

    // Scan sequencing, frame snapshot, overlay hold and request handshake
    always_comb begin
        state_s     = state_r;
        tick_s      = tick_r;
        digit_s     = digit_r;
        busy_s      = busy_r;
        frame_cnt_s = frame_cnt_r;
        ack_s       = 1'b0;
        case (state_r)
            BLANK: begin
                if (tick_r == BLANK_LAST) begin
                    state_s = ON;
                    tick_s  = {TW{1'b0}};
                end else begin
                    tick_s = tick_r + TICK_ONE;
                end
            end
            ON: begin
                if (tick_r == DIGIT_LAST) begin
                    state_s = BLANK;
                    tick_s  = {TW{1'b0}};
                    digit_s = digit_r + 2'd1;
                end else begin
                    tick_s = tick_r + TICK_ONE;
                end
            end
            default: begin
                state_s = BLANK;
                tick_s  = {TW{1'b0}};
            end
        endcase

        // Data is frozen for the whole frame; the source flag rides along with it
        if (snap_cycle_s) begin
            snap_s    = busy_r ? ovl_reg_r : base_val;
            showing_s = busy_r;
        end else begin
            snap_s    = snap_r;
            showing_s = showing_r;
        end

        if (frame_end_s && showing_r) begin
            if (frame_cnt_r == OVL_LAST) begin
                frame_cnt_s = {FW{1'b0}};
                busy_s      = 1'b0;
            end else begin
                frame_cnt_s = frame_cnt_r + FRAME_ONE;
            end
        end else begin
            frame_cnt_s = frame_cnt_r;
        end

        // Acceptance looks at the registered busy, so a request on the falling cycle waits one more
        if (ovl_req && !busy_r) begin
            ovl_reg_s = ovl_val;
            ack_s     = 1'b1;
            busy_s    = 1'b1;
        end else begin
            ovl_reg_s = ovl_reg_r;
        end
    end

    // Pin values for the upcoming cycle, derived from next-state so they line up with it
    always_comb begin
        case (digit_s)
            2'd0:    nib_s = snap_s[3:0];
            2'd1:    nib_s = snap_s[7:4];
            2'd2:    nib_s = snap_s[11:8];
            2'd3:    nib_s = snap_s[15:12];
            default: nib_s = snap_s[3:0];
        endcase
`ifdef LEADING_ZERO_BLANK_EN
        case (digit_s)
            2'd3:    lzb_s = !showing_s && (snap_s[15:12] == 4'h0);
            2'd2:    lzb_s = !showing_s && (snap_s[15:8] == 8'h00);
            2'd1:    lzb_s = !showing_s && (snap_s[15:4] == 12'h000);
            default: lzb_s = 1'b0;
        endcase
`else
        lzb_s = 1'b0;
`endif
        if (state_s == ON) begin
            an_s  = 4'b0001 << digit_s;
            seg_s = lzb_s ? SEG_BLANK : dec_s;
        end else begin
            an_s  = 4'b0000;
            seg_s = SEG_BLANK;
        end
    end

    hex_to_seg u_hex_to_seg (
        .nibble (nib_s),
        .seg    (dec_s)
    );

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= BLANK;
            tick_r      <= {TW{1'b0}};
            digit_r     <= 2'd0;
            snap_r      <= 16'h0000;
            ovl_reg_r   <= 16'h0000;
            busy_r      <= 1'b0;
            ack_r       <= 1'b0;
            showing_r   <= 1'b0;
            frame_cnt_r <= {FW{1'b0}};
            seg_r       <= SEG_BLANK;
            an_r        <= 4'b0000;
        end else begin
            state_r     <= state_s;
            tick_r      <= tick_s;
            digit_r     <= digit_s;
            snap_r      <= snap_s;
            ovl_reg_r   <= ovl_reg_s;
            busy_r      <= busy_s;
            ack_r       <= ack_s;
            showing_r   <= showing_s;
            frame_cnt_r <= frame_cnt_s;
            seg_r       <= seg_s;
            an_r        <= an_s;
        end
    end

    assign ovl_ack   = ack_r;
    assign ovl_busy  = busy_r;
    assign seg       = seg_r;
    assign an        = an_r;
    assign digit_idx = digit_r;

endmodule

// File: tb/tb_seg_scan_scheduler.sv
// Self-checking bench for seg_scan_scheduler: directed steps plus random traffic
// compared every cycle against a frame/phase arithmetic reference model.
module tb_seg_scan_scheduler;

    localparam int DT    = 4;
    localparam int BT    = 2;
    localparam int OF    = 2;
    localparam int SLOT  = DT + BT;
    localparam int FRAME = 4 * SLOT;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] base_val;
    logic        ovl_req;
    logic [15:0] ovl_val;
    logic        ovl_ack;
    logic        ovl_busy;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic [1:0]  digit_idx;

    always #5 clk = ~clk;

    seg_scan_scheduler #(
        .DIGIT_TICKS (DT),
        .BLANK_TICKS (BT),
        .OVL_FRAMES  (OF)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .base_val  (base_val),
        .ovl_req   (ovl_req),
        .ovl_val   (ovl_val),
        .ovl_ack   (ovl_ack),
        .ovl_busy  (ovl_busy),
        .seg       (seg),
        .an        (an),
        .digit_idx (digit_idx)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: m_t is the cycle position since reset, frames are FRAME cycles long
    int          m_t;
    logic [15:0] m_snap;
    logic [15:0] m_ovl;
    logic        m_busy;
    logic        m_ack;
    logic        m_show;
    int          m_frames;

    logic [6:0] hex_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h at model cycle %0d", tag, obs, exp, m_t);
        end
    endtask

    function automatic logic [6:0] exp_glyph(input int d);
        logic [15:0] sh;
        logic [6:0]  g;
        sh = m_snap >> (4 * d);
        g  = hex_tab[sh[3:0]];
`ifdef LEADING_ZERO_BLANK_EN
        if (!m_show && d > 0 && sh == 16'h0000) g = 7'h00;
`endif
        return g;
    endfunction

    task automatic check_outputs();
        int         p;
        int         d;
        logic       on;
        logic [3:0] exp_an;
        logic [6:0] exp_seg;
        p  = m_t % FRAME;
        d  = p / SLOT;
        on = (p % SLOT) >= BT;
        exp_an  = on ? (4'b0001 << d) : 4'b0000;
        exp_seg = on ? exp_glyph(d) : 7'h00;
        chk("an", {12'h000, an}, {12'h000, exp_an});
        chk("seg", {9'h000, seg}, {9'h000, exp_seg});
        chk("digit_idx", {14'h0000, digit_idx}, 16'(d));
        chk("ovl_ack", {15'h0000, ovl_ack}, {15'h0000, m_ack});
        chk("ovl_busy", {15'h0000, ovl_busy}, {15'h0000, m_busy});
    endtask

    // One clock: advance the model with the inputs present at the edge, then compare
    task automatic tick();
        int   p;
        logic acc;
        @(posedge clk);
        if (rst) begin
            m_t = 0; m_snap = 16'h0000; m_ovl = 16'h0000;
            m_busy = 1'b0; m_ack = 1'b0; m_show = 1'b0; m_frames = 0;
        end else begin
            p   = m_t % FRAME;
            acc = ovl_req && !m_busy;
            if (p == BT - 1) begin
                m_snap = m_busy ? m_ovl : base_val;
                m_show = m_busy;
            end
            if (p == FRAME - 1 && m_show) begin
                m_frames++;
                if (m_frames == OF) begin
                    m_frames = 0;
                    m_busy   = 1'b0;
                end
            end
            m_ack = acc;
            if (acc) begin
                m_ovl  = ovl_val;
                m_busy = 1'b1;
            end
            m_t++;
        end
        #1;
        check_outputs();
    endtask

    task automatic wait_dut_ack(input string tag);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (ovl_ack !== 1'b1 && n < 300);
        chk(tag, {15'h0000, ovl_ack}, 16'h0001);
    endtask

    task automatic run_to_phase(input int ph);
        for (int i = 0; i < FRAME && (m_t % FRAME) != ph; i++) tick();
    endtask

    initial begin
        rst = 1'b1; base_val = 16'h1234; ovl_req = 1'b0; ovl_val = 16'h0000;
        tick(); tick();
        rst = 1'b0;
        repeat (FRAME + 6) tick();

        // Mid-frame base change must wait for the next snapshot
        run_to_phase(BT + SLOT + 1);
        base_val = 16'h5678;
        repeat (2 * FRAME) tick();

        // Overlay accepted mid-frame, then a second request held while busy
        run_to_phase(10);
        ovl_req = 1'b1; ovl_val = 16'hE0F0;
        wait_dut_ack("ack_e0f0");
        ovl_req = 1'b0;
        repeat (5) tick();
        ovl_req = 1'b1; ovl_val = 16'hAAAA;
        wait_dut_ack("ack_aaaa");
        ovl_req = 1'b0;
        repeat (3 * FRAME) tick();

        // Reset while an overlay digit is lit
        ovl_req = 1'b1; ovl_val = 16'($urandom);
        wait_dut_ack("ack_pre_reset");
        ovl_req = 1'b0;
        for (int i = 0; i < 3 * FRAME && !(m_show && (m_t % FRAME) == BT + SLOT); i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (FRAME + 6) tick();

        // Random traffic
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 19) == 0) base_val = 16'($urandom);
            if (!ovl_req && $urandom_range(0, 29) == 0) begin
                ovl_req = 1'b1;
                ovl_val = 16'($urandom);
            end
            tick();
            if (m_ack) ovl_req = 1'b0;
        end
        ovl_req = 1'b0;

        // Leading-zero handling on a base frame
        base_val = 16'h0042;
        for (int i = 0; i < 4 * FRAME && m_busy; i++) tick();
        repeat (2 * FRAME + 4) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seg_scan_scheduler.md
Name: seg_scan_scheduler

Overview:
- Time-multiplexed scan controller for the 4-digit seven-segment display.
- Shares the display between two requesters:
  - the default base source (encoder/lock state, always present);
  - a timed overlay source (status messages such as OPEN/Err), accepted via a req/ack handshake.
- Sequences digit anodes with anti-ghosting blanking, snapshots data per frame, drives segment/anode pins directly.

Parameters:
- DIGIT_TICKS, 1000, clock cycles each digit is lit (>=1)
- BLANK_TICKS, 16, clock cycles all anodes off before each digit (>=1)
- OVL_FRAMES, 64, complete scan frames an accepted overlay is held (>=1)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- base_val  in  16  default display value; digit0=[3:0] ... digit3=[15:12]
- ovl_req  in  1  overlay request, level; held until ack
- ovl_val  in  16  overlay value, same nibble order; valid while ovl_req=1
- ovl_ack  out  1  one-cycle pulse: overlay accepted
- ovl_busy  out  1  overlay pending or displayed
- seg  out  7  segments {g,f,e,d,c,b,a}, active-high
- an  out  4  digit enable, one-hot active-high, 0 during blank
- digit_idx  out  2  digit currently scanned

Behaviour:
- All outputs registered. Reset (sync, rst=1 at clk edge) gives:
  - state=BLANK, digit_idx=0, tick counter=0;
  - an=0, seg=0, ovl_ack=0, ovl_busy=0;
  - frame snapshot=0, overlay register cleared, pending/active overlay discarded, no ack.
- FSM states:
  - BLANK: an=0, seg=0 for BLANK_TICKS cycles, then ON.
  - ON: an=onehot(digit_idx), seg=decode(snapshot nibble[digit_idx]) for DIGIT_TICKS cycles. Then digit_idx increments mod 4 (3->0 wraps) and state returns to BLANK.
- Frame = 4*(BLANK_TICKS+DIGIT_TICKS) cycles. Frame end = last ON cycle with digit_idx=3.
- Snapshot: on the last BLANK cycle with digit_idx=0, snapshot <= overlay register if overlay armed, else base_val. Mid-frame input changes never appear until the next frame (no tearing).
- Handshake:
  - Accept when ovl_req=1 and ovl_busy=0. That cycle: capture ovl_val.
  - Next cycle: ovl_ack=1 for exactly one cycle, ovl_busy=1, overlay armed.
  - Requests while busy: ignored, no ack.
- Overlay hold:
  - The overlay is shown starting at the next frame snapshot. A partial frame in progress at acceptance does not count.
  - A frame counter increments at each frame end while the overlay is displayed.
  - At the frame end completing OVL_FRAMES: ovl_busy<=0, overlay disarmed; the next snapshot takes base_val.
- Simultaneous events:
  - A req present on the cycle busy falls is not accepted that cycle; it is accepted the following cycle.
  - If its ack lands before the next snapshot, the overlay shows from that frame.
- Counter widths: $clog2(max(DIGIT_TICKS,BLANK_TICKS)+1) and $clog2(OVL_FRAMES+1). Counters compare against TICKS-1; no overflow.
- Decode: hex 0-F standard. 0=7'h3F, 1=7'h06, 2=7'h5B, 3=7'h4F, 4=7'h66, 8=7'h7F, A=7'h77, E=7'h79, F=7'h71.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN
- Defined: for base-source frames only, zero nibbles scanning from digit3 downward up to the first nonzero nibble give seg=0. The anode still follows the scan. digit0 is always decoded. Overlay frames are unaffected.
- Undefined: every nibble is decoded, so leading zeros show 7'h3F.

Decomposition:
- Package csit_luks_pkg:
  - seg_t (7-bit) typedef;
  - 16 hex glyph constants SEG_HEX_0..SEG_HEX_F;
  - SEG_BLANK=7'h00;
  - scan_state_t enum {BLANK, ON}.
- Sub-module hex_to_seg: combinational 4-bit nibble -> seg_t, reused elsewhere.
- Scheduler holds the FSM, counters, snapshot and handshake.

Test Plan (DIGIT_TICKS=4, BLANK_TICKS=2, OVL_FRAMES=2):
- Reset/scan: rst released, base_val=16'h1234. Required sequence:
  - an=0 for 2 cycles;
  - an=4'b0001, seg=7'h66 for 4 cycles;
  - blank 2; an=4'b0010, seg=7'h4F; then 4'b0100/7'h5B; then 4'b1000/7'h06;
  - period 24 cycles, wraps to digit0.
- Anti-tear: base_val changed 1234->5678 during digit1 ON. Remaining digits of the frame still show 1234; the next frame shows 5678.
- Overlay: ovl_req=1, ovl_val=16'hE0F0 mid-frame:
  - ack pulses exactly 1 cycle, busy=1;
  - next frame digit0 seg=7'h3F, digit1 7'h71;
  - exactly 2 frames shown; busy falls at 2nd frame end; base value returns.
- Busy contention: second req with 16'hAAAA held during overlay:
  - no ack while busy=1;
  - ack the cycle after busy falls (+1);
  - 7'h77 on all digits for 2 frames.
- Reset mid-overlay: rst=1 for 1 cycle during an ON digit. Next cycle an=0, seg=0, busy=0, ack=0. After release, base_val shows with no residual overlay.
- LEADING_ZERO_BLANK_EN, base_val=16'h0042:
  - with macro: digit3, digit2 seg=0; digit1 7'h66; digit0 7'h5B;
  - without macro: digit3, digit2 show 7'h3F.
